// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the core's memory stage and the
// load/store unit. "master" is the core side and "slave" is the unit side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
// requests into word accesses on a combinational-read, single-port word memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a request, req_ready high
//   LOAD     | memory word addressed, extracted load data captured at end
//   STORE_RD | old word read, merged sub-word data captured at end
//   STORE_WR | mem_we high, memory writes on the closing edge
//   RESP     | response held until resp_ready
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] STORE_RD = 3'd2;
  localparam logic [2:0] STORE_WR = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]  state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        illegal_f3;
  logic        misaligned;
  logic        out_of_window;
  logic        req_err;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
  assign illegal_f3 = bus.req_we ? (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11))
                                 : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign out_of_window = (bus.req_addr[31:ADDR_W+2] != '0);
  assign req_err = illegal_f3 || misaligned || out_of_window;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  // Decoded from state alone so an async reset drops the write strobe at once.
  assign mem_we = (state == STORE_WR);

  // Lane extraction and sign/zero extension of the addressed memory word.
  always_comb begin
    byte_val = mem_rdata[{addr_q, 3'b000} +: 8];
    half_val = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{byte_val[7] & ~funct3_q[2]}}, byte_val};
      2'b01:   load_data = {{16{half_val[15] & ~funct3_q[2]}}, half_val};
      default: load_data = mem_rdata;
    endcase
  end

  // Splice the store byte/half into the old word for read-modify-write.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Request sequencing FSM with registered memory address/data and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      funct3_q  <= 3'b000;
      addr_q    <= 2'b00;
      wdata_q   <= 16'h0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q  <= bus.req_funct3;
            addr_q    <= bus.req_addr[1:0];
            wdata_q   <= bus.req_wdata[15:0];
            mem_addr  <= bus.req_addr[ADDR_W+1:2];
            mem_wdata <= bus.req_wdata;
            rdata_q   <= 32'h0;
            err_q     <= req_err;
            if (req_err)
              state <= RESP;
            else if (!bus.req_we)
              state <= LOAD;
            else if (bus.req_funct3[1:0] == 2'b10)
              state <= STORE_WR;
            else
              state <= STORE_RD;
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          state   <= RESP;
        end
        STORE_RD: begin
          mem_wdata <= merged;
          state     <= STORE_WR;
        end
        STORE_WR: state <= RESP;
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute/memory stage and the 256×32 word-addressed `data_memory`. It turns RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on that memory. Sub-word stores are done as read-modify-write, and load data is lane-extracted and sign- or zero-extended. Requests and responses use valid/ready handshakes, so the core can stall on memory latency.

## Interface
Parameters:
- `ADDR_W`, default 8: memory word-address width (256 words). The byte window is `2^(ADDR_W+2)` = 1024 bytes.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  unit can accept a request; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 (size/sign)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; low byte/half used for SB/SH
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  core consumes the response
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned, out-of-window or illegal funct3
- `mem_addr`  out  ADDR_W  word address to `data_memory.address`
- `mem_we`  out  1  to `data_memory.w_en`
- `mem_wdata`  out  32  to `data_memory.wr_data`
- `mem_rdata`  in  32  from `data_memory.rd_data` (combinational read)

## Operation
- States: IDLE, LOAD, STORE_RD, STORE_WR, RESP.
- **Accept** happens on a rising edge with `req_valid && req_ready`. It latches `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
- **Error check at accept.** Any of the following sets `err`, goes straight to RESP, and makes no memory write:
  - illegal funct3: loads 011/110/111; stores 011 and 1xx;
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - `addr[31:ADDR_W+2]≠0`.
- **Next state after a clean accept:**
  - load → LOAD;
  - SW → STORE_WR;
  - SB/SH → STORE_RD.
- **LOAD:** capture the extracted word into `resp_rdata`, then go to RESP.
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **STORE_RD:** capture `mem_rdata` and form the merged word in the `mem_wdata` register, then go to STORE_WR.
  - SB replaces byte `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half `addr[1]` with `wdata[15:0]`.
- **STORE_WR:** `mem_we=1` for exactly this one cycle; the memory writes on the closing edge. Then go to RESP. For SW, `mem_wdata` is the latched `req_wdata`.
- **RESP:** `resp_valid=1`, held with `resp_rdata`/`resp_err` stable until `resp_ready`. On the edge with `resp_valid && resp_ready`, go to IDLE.
- **Output decoding and registration:**
  - `mem_addr` = latched `addr[ADDR_W+1:2]`, registered.
  - `mem_we` is decoded from state only; never high outside STORE_WR.
  - `req_ready` = (state==IDLE); `resp_valid` = (state==RESP).

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- Edge E0 below is the accept edge.
- Response latency:

  | Request | `resp_valid` high | Notes |
  |---|---|---|
  | Load | cycle after E1 | 2 edges after accept |
  | SW | cycle after E1 | memory written at E1 |
  | SB/SH | cycle after E2 | read at E1, written at E2 |
  | Error | cycle after E0 | — |

- Throughput: no new request is accepted until the RESP handshake edge completes. The next accept is possible on the edge after that, since `req_ready` is back to 1 in IDLE.
- `resp_ready` high while entering RESP still gives `resp_valid` for at least one full cycle.
- `req_valid` outside IDLE is ignored; the core holds it.
- Reset mid-operation (`rst_n` low at any time) forces IDLE asynchronously and `mem_we` to 0 immediately.
  - A pending RMW write is dropped and memory keeps its old word.
  - No response is issued for the aborted request.

## Test plan
Preload `mem[4]=0x123480F0`.
1. LB 0x10 → `resp_rdata`=0xFFFFFFF0; LBU 0x11 → 0x00000080; LH 0x10 → 0xFFFF80F0; LHU 0x12 → 0x00001234; LW 0x10 → 0x123480F0. Each has `resp_valid` 2 cycles after accept and `err`=0.
2. SB 0x13, wdata 0x000000AB → STORE_RD then STORE_WR with `mem_we` high exactly 1 cycle. `mem[4]`=0xAB3480F0 and `resp_valid` 3 cycles after accept. Then SH 0x10, wdata 0xBEEF → `mem[4]`=0xAB34BEEF.
3. SW 0x14, data 0xDEADBEEF → `mem[5]`=0xDEADBEEF with response 2 cycles after accept. Back-to-back LW 0x14 accepted the cycle after the handshake returns 0xDEADBEEF.
4. SH 0x11, LW 0x12, LB 0x400, load funct3 011 → `resp_err`=1 one cycle after accept, `mem_we` never high, `resp_rdata`=0, memory unchanged.
5. Hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid`, `resp_rdata` and `resp_err` stable and `req_ready`=0 throughout. Raise `resp_ready` → IDLE next edge.
6. Assert `rst_n`=0 during STORE_RD of SB 0x10 → `mem_we` stays 0, `mem[4]` unchanged, all outputs at reset values. After release, a new LW 0x10 works normally.
